// File: rtl/mem_m10k_mp.sv
// mem_m10k_mp: multi-channel block RAM, round-robin write and read arbiters sharing one RAM.
// Write-first forwarding on same-word read/write; out-of-range accesses complete with an error flag.
module mem_m10k_mp #(
  parameter int N_PORTS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int N_ADDR_BITS = 12,
  parameter logic [31:0] ADDR = 32'h0000_0000,
  parameter int RD_LATENCY = 1,
  parameter MIF_FILENAME = ""
) (
  input  logic clock,
  input  logic reset_n,
  input  logic [N_PORTS-1:0] wr_valid,
  input  logic [N_PORTS*32-1:0] wr_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [N_PORTS*(DATA_WIDTH/8)-1:0] wr_byteEn,
  output logic [N_PORTS-1:0] wr_ready,
  output logic [N_PORTS-1:0] wr_err,
  input  logic [N_PORTS-1:0] rd_valid,
  input  logic [N_PORTS*32-1:0] rd_addr,
  output logic [N_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [N_PORTS-1:0] rd_ready,
  output logic [N_PORTS-1:0] rd_err
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OB = $clog2(BYTES);
  localparam int AW = N_ADDR_BITS - OB;
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam logic [32:0] LO = {1'b0, ADDR};
  localparam logic [32:0] HI = LO + (33'd1 << N_ADDR_BITS);

  logic [DATA_WIDTH-1:0] mem [2**AW];

  // Returns {granted, channel}: first requester at or after ptr, wrapping.
  function automatic logic [PW:0] rr(input logic [N_PORTS-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] k;
    rr = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % N_PORTS);
      if (req[k]) rr = {1'b1, k};
    end
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return PW'((int'(p) + 1) % N_PORTS);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return {1'b0, a} >= LO && {1'b0, a} < HI;
  endfunction

  logic [PW-1:0] wr_ptr, rd_ptr, w_sel, r_sel, s1_ch;
  logic w_go, r_go, w_in, s1_v, s1_err;
  logic [N_PORTS-1:0] outst, r_oh, s1_hit, s2_ready, s2_err;
  logic [31:0] wa, ra;
  logic [AW-1:0] wi, ri;
  logic [DATA_WIDTH-1:0] wd, q, fwd_d, merged, d1;
  logic [BYTES-1:0] wbe, fwd_be;
  logic [DATA_WIDTH-1:0] held [N_PORTS];

  assign {w_go, w_sel} = rr(wr_valid & ~wr_ready, wr_ptr);
  assign {r_go, r_sel} = rr(rd_valid & ~outst & ~rd_ready, rd_ptr);
  assign wa = wr_addr[32*int'(w_sel) +: 32];
  assign ra = rd_addr[32*int'(r_sel) +: 32];
  assign wd = wr_data[DATA_WIDTH*int'(w_sel) +: DATA_WIDTH];
  assign wbe = wr_byteEn[BYTES*int'(w_sel) +: BYTES];
  assign w_in = in_rng(wa);
  assign wi = wa[N_ADDR_BITS-1:OB];
  assign ri = ra[N_ADDR_BITS-1:OB];
  assign r_oh = N_PORTS'(r_go) << r_sel;
  assign s1_hit = N_PORTS'(s1_v) << s1_ch;

  // RAM reads old contents; same-word write bytes are merged in afterwards (write-first).
  always_ff @(posedge clock) begin
    if (w_go && w_in)
      for (int b = 0; b < BYTES; b++)
        if (wbe[b]) mem[wi][8*b +: 8] <= wd[8*b +: 8];
    q <= mem[ri];
    fwd_be <= (w_go && w_in && wi == ri) ? wbe : '0;
    fwd_d <= wd;
  end

  always_comb begin
    merged = q;
    for (int b = 0; b < BYTES; b++)
      if (fwd_be[b]) merged[8*b +: 8] = fwd_d[8*b +: 8];
    d1 = s1_err ? '0 : merged;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_ready <= '0;
      wr_err <= '0;
      outst <= '0;
      s1_v <= 1'b0;
      s1_ch <= '0;
      s1_err <= 1'b0;
      s2_ready <= '0;
      s2_err <= '0;
      for (int c = 0; c < N_PORTS; c++) held[c] <= '0;
    end else begin
      wr_ready <= '0;
      wr_err <= '0;
      if (w_go) begin
        wr_ready[w_sel] <= 1'b1;
        wr_err[w_sel] <= !w_in;
        wr_ptr <= nxt(w_sel);
      end
      if (r_go) rd_ptr <= nxt(r_sel);
      outst <= (outst & ~rd_ready) | r_oh;
      s1_v <= r_go;
      s1_ch <= r_sel;
      s1_err <= !in_rng(ra);
      s2_ready <= s1_hit;
      s2_err <= s1_hit & {N_PORTS{s1_err}};
      for (int c = 0; c < N_PORTS; c++)
        if (s1_hit[c]) held[c] <= d1;
    end
  end

  // Latency 1 shows the merged RAM word during the pulse; held[] keeps it afterwards.
  for (genvar c = 0; c < N_PORTS; c++) begin : g_rd
    assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = (RD_LATENCY == 1 && s1_hit[c]) ? d1 : held[c];
  end

  assign rd_ready = RD_LATENCY == 1 ? s1_hit : s2_ready;
  assign rd_err = RD_LATENCY == 1 ? (s1_hit & {N_PORTS{s1_err}}) : s2_err;
endmodule
